// File: rtl/modred_wlm_pipe.sv
// modred_wlm_pipe: pipelined word-level Montgomery reducer for
// q = qH*2^W + 1 with per-sample qH, tag side channel, valid/ready.
// Ports: clk, reset (sync, active-high);
//   in_valid/in_ready, in_t (T < q*R), in_qh, in_tag;
//   out_valid/out_ready, out_c = T*R^-1 mod q in [0,q), out_tag.
module modred_wlm_pipe #(
  parameter int DATA_W = 32,
  parameter int W      = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_t,
  input  logic [DATA_W-W-1:0] in_qh,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_c,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int QH_W = DATA_W - W;
  // One spare bit over the widest legal T.
  localparam int TW   = 2*DATA_W + 1;
  localparam int SW   = TW - W;

  logic en;

  logic [TW-1:0]     t_src   [STAGES];
  logic [QH_W-1:0]   qh_src  [STAGES];
  logic [TAG_W-1:0]  tag_src [STAGES];
  logic              v_src   [STAGES];

  // level a: qH*m, T>>W, carry
  logic [DATA_W-1:0] prod_q [STAGES];
  logic [DATA_W-1:0] prod_d [STAGES];
  logic [SW-1:0]     shr_q  [STAGES];
  logic [SW-1:0]     shr_d  [STAGES];
  logic              cy_q   [STAGES];
  logic              cy_d   [STAGES];
  logic [QH_W-1:0]   qha_q  [STAGES];
  logic [QH_W-1:0]   qha_d  [STAGES];
  logic [TAG_W-1:0]  taga_q [STAGES];
  logic [TAG_W-1:0]  taga_d [STAGES];
  logic              va_q   [STAGES];
  logic              va_d   [STAGES];

  // level b: T_{k+1}
  logic [TW-1:0]     tb_q   [STAGES];
  logic [TW-1:0]     tb_d   [STAGES];
  logic [QH_W-1:0]   qhb_q  [STAGES];
  logic [QH_W-1:0]   qhb_d  [STAGES];
  logic [TAG_W-1:0]  tagb_q [STAGES];
  logic [TAG_W-1:0]  tagb_d [STAGES];
  logic              vb_q   [STAGES];
  logic              vb_d   [STAGES];

  logic [DATA_W-1:0] out_c_q, out_c_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_valid_q, out_valid_d;

  logic [TW-1:0]     s_fin;
  logic [TW-1:0]     q_fin;
  logic [TW-1:0]     diff;

  assign en        = !out_valid_q | out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_tag   = out_tag_q;

  always_comb begin
    t_src[0]   = {1'b0, in_t};
    qh_src[0]  = in_qh;
    tag_src[0] = in_tag;
    v_src[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      t_src[k]   = tb_q[k-1];
      qh_src[k]  = qhb_q[k-1];
      tag_src[k] = tagb_q[k-1];
      v_src[k]   = vb_q[k-1];
    end
  end

  always_comb begin
    logic [W-1:0] lo;
    logic [W-1:0] m;
    lo = '0;
    m  = '0;
    for (int k = 0; k < STAGES; k++) begin
      lo = t_src[k][W-1:0];
      // m = -L mod 2^W makes T + q*m divisible by 2^W
      m  = '0 - lo;
      prod_d[k] = {{W{1'b0}}, qh_src[k]} *
                  {{QH_W{1'b0}}, m};
      shr_d[k]  = t_src[k][TW-1:W];
      cy_d[k]   = |lo;
      qha_d[k]  = qh_src[k];
      taga_d[k] = tag_src[k];
      va_d[k]   = v_src[k];
      tb_d[k]   = TW'(prod_q[k]) + TW'(shr_q[k])
                + TW'(cy_q[k]);
      qhb_d[k]  = qha_q[k];
      tagb_d[k] = taga_q[k];
      vb_d[k]   = va_q[k];
    end
  end

  always_comb begin
    s_fin = tb_q[STAGES-1];
    q_fin = TW'({qhb_q[STAGES-1], {W{1'b0}}}) + TW'(1);
    diff  = s_fin - q_fin;
    out_c_d     = (s_fin >= q_fin) ? diff[DATA_W-1:0]
                                   : s_fin[DATA_W-1:0];
    out_tag_d   = tagb_q[STAGES-1];
    out_valid_d = vb_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q      <= '{default: '0};
      shr_q       <= '{default: '0};
      cy_q        <= '{default: 1'b0};
      qha_q       <= '{default: '0};
      taga_q      <= '{default: '0};
      va_q        <= '{default: 1'b0};
      tb_q        <= '{default: '0};
      qhb_q       <= '{default: '0};
      tagb_q      <= '{default: '0};
      vb_q        <= '{default: 1'b0};
      out_c_q     <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      prod_q      <= prod_d;
      shr_q       <= shr_d;
      cy_q        <= cy_d;
      qha_q       <= qha_d;
      taga_q      <= taga_d;
      va_q        <= va_d;
      tb_q        <= tb_d;
      qhb_q       <= qhb_d;
      tagb_q      <= tagb_d;
      vb_q        <= vb_d;
      out_c_q     <= out_c_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_modred_wlm_pipe.sv
// tb_modred_wlm_pipe: random and directed checks of modred_wlm_pipe
// against a modular-halving reference model with a scoreboard.
module tb_modred_wlm_pipe;

  localparam int DATA_W = 32;
  localparam int W      = 16;
  localparam int STAGES = 2;
  localparam int TAG_W  = 8;
  localparam int LAT    = 2*STAGES + 1;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [2*DATA_W-1:0] in_t;
  logic [DATA_W-W-1:0] in_qh;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_c;
  logic [TAG_W-1:0]    out_tag;

  modred_wlm_pipe #(
    .DATA_W(DATA_W), .W(W), .STAGES(STAGES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_t(in_t), .in_qh(in_qh), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] c;
    logic [TAG_W-1:0]  tag;
    int                adv;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int adv = 0;
  bit acc = 0;
  bit prev_rst = 0;
  bit hold = 0;
  logic [DATA_W-1:0] hold_c;
  logic [TAG_W-1:0]  hold_tag;
  bit ovr_en = 0;
  logic [DATA_W-1:0] ovr_c = '0;

  function automatic void chk(string name, logic [63:0] got,
                              logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endfunction

  // T*2^-(W*STAGES) mod q by repeated halving modulo odd q.
  function automatic logic [DATA_W-1:0] gold(
    logic [63:0] t, logic [DATA_W-W-1:0] qh);
    longint unsigned q;
    longint unsigned x;
    q = (longint'(qh) << W) + 1;
    x = t % q;
    for (int i = 0; i < W*STAGES; i++)
      x = x[0] ? (x + q) >> 1 : x >> 1;
    return x[DATA_W-1:0];
  endfunction

  function automatic logic [63:0] rand_t(logic [DATA_W-W-1:0] qh);
    logic [63:0] r;
    longint unsigned q;
    r = {$urandom(), $urandom()};
    q = (longint'(qh) << W) + 1;
    return r % (q << (W*STAGES));
  endfunction

  task automatic mon();
    bit due;
    exp_t e;
    acc = 0;
    if (reset) begin
      sbq.delete();
      hold = 0;
      prev_rst = 1;
    end else begin
      if (prev_rst) begin
        chk("rst_valid", out_valid, 0);
        chk("rst_c", out_c, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_ready", in_ready, 1);
        prev_rst = 0;
      end
      if (hold) begin
        chk("hold_c", out_c, hold_c);
        chk("hold_tag", out_tag, hold_tag);
        hold = 0;
      end
      chk("in_ready", in_ready, !out_valid || out_ready);
      due = sbq.size() > 0 && (adv - sbq[0].adv) == LAT;
      chk("out_valid", out_valid, due);
      if (out_valid && due) begin
        if (out_ready) begin
          e = sbq.pop_front();
          chk("out_c", out_c, e.c);
          chk("out_tag", out_tag, e.tag);
        end else begin
          hold = 1;
          hold_c = out_c;
          hold_tag = out_tag;
        end
      end
      if (in_valid && in_ready) begin
        e.c = ovr_en ? ovr_c : gold(in_t, in_qh);
        e.tag = in_tag;
        e.adv = adv;
        sbq.push_back(e);
        acc = 1;
      end
      if (in_ready) adv++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] t,
                      input logic [DATA_W-W-1:0] qh,
                      input logic [TAG_W-1:0] tag,
                      input bit oe, input logic [DATA_W-1:0] oc);
    in_t = t; in_qh = qh; in_tag = tag;
    ovr_en = oe; ovr_c = oc;
    in_valid = 1;
    for (int g = 0; g < 50; g++) begin
      step();
      if (acc) break;
    end
    chk("accept", acc, 1);
    ovr_en = 0;
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int g = 0; g < 40 && sbq.size() > 0; g++) step();
    chk("drain_empty", sbq.size(), 0);
    step();
    step();
  endtask

  initial begin
    logic [63:0] t;
    logic [DATA_W-W-1:0] qh;
    int n;
    reset = 1; in_valid = 0; in_t = '0; in_qh = 16'h1;
    in_tag = '0; out_ready = 1;
    step();
    step();
    reset = 0;

    // directed, q = 65537 (R^-1 = 1)
    send(64'd0, 16'h1, 8'h01, 1, 32'd0);
    send(64'd1, 16'h1, 8'h02, 1, 32'd1);
    send(64'd65536, 16'h1, 8'h03, 1, 32'd65536);
    send(64'h1_0000_0000, 16'h1, 8'h04, 1, 32'd1);
    send(64'd65537, 16'h1, 8'h05, 1, 32'd0);
    send(64'd65537 * 64'd12345, 16'h1, 8'h06, 1, 32'd0);
    send((64'd65537 << 32) - 64'd1, 16'h1, 8'h07, 0, '0);
    // q = 1
    send({32'd0, $urandom()}, 16'h0, 8'h08, 1, 32'd0);
    // T multiple of large q
    t = 64'h3001_0001 * 64'd777;
    send(t, 16'h3001, 8'h09, 1, 32'd0);
    drain();

    // mixed moduli, back to back
    for (int i = 0; i < 1000; i++) begin
      qh = i[0] ? 16'h3001 : 16'h0001;
      send(rand_t(qh), qh, i[7:0], 0, '0);
    end
    drain();

    // backpressure: out_ready low 5 cycles mid-stream
    n = 0;
    qh = 16'h3001;
    t = rand_t(qh);
    for (int j = 0; j < 80 && n < 20; j++) begin
      in_valid = 1; in_t = t; in_qh = qh; in_tag = 8'h40 + n[7:0];
      out_ready = !(j >= 10 && j < 15);
      step();
      if (acc) begin
        n++;
        t = rand_t(qh);
      end
    end
    chk("bp_sent", n, 20);
    drain();

    // bubbles 1,0,0,1
    in_qh = 16'h1; in_tag = 8'h80;
    in_t = rand_t(16'h1); in_valid = 1; step();
    in_valid = 0; step(); step();
    in_tag = 8'h81; in_t = rand_t(16'h1); in_valid = 1; step();
    drain();

    // reset with 4 samples in flight
    for (int i = 0; i < 4; i++)
      send(rand_t(16'h3001), 16'h3001, 8'hA0 + i[7:0], 0, '0);
    in_valid = 0;
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 8; i++) step();
    send(rand_t(16'h3001), 16'h3001, 8'hB0, 0, '0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
